moonbase_cpu_4bit: RTL and testbench
====================================

MOONBASE_CPU_4BIT -- requirements
Module: moonbase_cpu_4bit

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 1000, meaning the number of idle clocks after reset release before the first fetch.
REQ-002 SHALL have io_in[0] (clk), input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have io_in[1] (rst), input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have io_in[5:2], input, 4 bits: memory/device read data nibble.
REQ-005 SHALL have io_in[7:6], input, 2 bits: general input port.
REQ-006 SHALL have io_out[7], output, 1 bit: address strobe; 1 = address phase with address on io_out[6:0].
REQ-007 SHALL have io_out[6:0], output, 7 bits: address in the address phase; in the data phase, bit 5 = SRAM write strobe (active-low), bit 4 = device write strobe (active-low), [3:0] = write data.

Function
REQ-008 SHALL use registers A (4 bits), X (7 bits) and PC (7 bits); all arithmetic is modulo 16 on A and modulo 128 on addresses/PC.
REQ-009 SHALL perform every bus access as two consecutive clocks: address phase (io_out[7]=1, io_out[6:0]=addr), then data phase (io_out[7]=0).
REQ-010 SHALL, in a read data phase, drive io_out[5:4]=2'b11 and sample io_in[5:2] on the closing rising edge.
REQ-011 SHALL, in a write data phase, drive data on io_out[3:0] with exactly one strobe low (bit 5 SRAM, bit 4 device) for that one clock.
REQ-012 SHALL run states WAIT, then per instruction FETCH_A/FETCH_D (opcode at PC), OPn_A/OPn_D (1 or 2 operand nibbles at PC+1, PC+2), and MEM_A/MEM_D where needed; PC advances by the instruction length.
REQ-013 SHALL decode opcodes 0..4 (d): A = A op mem[X+d] with ops add, sub (A-mem), or, and, xor.
REQ-014 SHALL decode opcode 5 (d) as A = mem[X+d], 6 (i) as A = A+i, 7 as a 2-nibble no-op, 8 (i) as A = i.
REQ-015 SHALL decode opcode 9 (ignored nibble) as A = {2'b00, io_in[7:6]} when the input-port macro is defined.
REQ-016 SHALL decode opcode A (d) as a device write of A to address X+d (io_out[4] low), and opcode B (d) as an SRAM write of A to X+d (io_out[5] low).
REQ-017 SHALL decode opcode C (hi,lo) as X = {hi,lo}[6:0], D (hi,lo) as PC = {hi,lo}[6:0] if A!=0, E (hi,lo) as the same jump if A==0, F (hi,lo) as an unconditional jump.
REQ-018 SHALL continue to the next sequential instruction when a conditional jump is not taken; X+d wraps within 128 addresses and PC wraps 0x7f->0x00.
REQ-019 SHALL, in WAIT, count MAX_COUNT clocks with io_out idle (8'h30) and then enter FETCH_A at PC=0.

Reset
REQ-020 SHALL, while rst is low, immediately force A=0, X=0, PC=0, state WAIT, count=0, and io_out=8'h30 (no strobes active), regardless of any instruction in progress.
REQ-021 SHALL cancel a pending write on reset mid-instruction, leaving no partial strobe.

Configuration
REQ-022 SHALL define MOONBASE_INPUT_PORT_EN to enable opcode 9 as specified; without it, opcode 9 SHALL be a 2-nibble no-op and io_in[7:6] SHALL be ignored.

Structure
REQ-023 SHALL place the opcode constants, state enumeration and idle output value in package moonbase_cpu_pkg.
REQ-024 SHALL implement the 4-bit combinational ALU (add/sub/or/and/xor/pass/add-imm) as sub-module moonbase_alu.

Verification
REQ-025 SHALL cover a count loop at 0x00: 8 0, C 5 0, A E, B 0, 8 1, 0 0, D 0 5 -> device writes to 0x5e of 0,1,...,15, then fall-through to 0x10 with A=0.
REQ-026 SHALL cover the ALU: mem[0x50]=0xA, A=0xC, then sub/or/and/xor/mov each followed by A E -> device writes 0x2, 0xE, 0x8, 0x6, 0xA.
REQ-027 SHALL cover F 3 0 at 0x30 -> fetch addresses repeat 0x30,0x31,0x32 forever, with no writes.
REQ-028 SHALL cover reset asserted during MEM_D of opcode B -> io_out=8'h30 at once, no SRAM write, and first fetch at address 0 after MAX_COUNT clocks.
REQ-029 SHALL cover the MOONBASE_INPUT_PORT_EN build with io_in[7:6]=2'b10 and program 9 0, A 0 -> device write value 0x2; in the build without the macro the value written SHALL be the prior A.
REQ-030 SHALL cover wrap: X=0x7f, B 2 -> SRAM write at address 0x01.

Source files
------------

// File: rtl/moonbase_cpu_pkg.sv
// Shared constants for the moonbase 4-bit CPU: opcodes, FSM states, ALU ops, idle bus value.
package moonbase_cpu_pkg;

    localparam logic [7:0] IDLE_OUT = 8'h30;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LDM  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_NOP  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_IN   = 4'h9;
    localparam logic [3:0] OP_DEVW = 4'hA;
    localparam logic [3:0] OP_STM  = 4'hB;
    localparam logic [3:0] OP_LDX  = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    typedef enum logic [3:0] {
        ST_WAIT,
        ST_FETCH_A,
        ST_FETCH_D,
        ST_OP1_A,
        ST_OP1_D,
        ST_OP2_A,
        ST_OP2_D,
        ST_MEM_A,
        ST_MEM_D
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_AND,
        ALU_XOR,
        ALU_PASS,
        ALU_ADDI
    } alu_op_e;

    // Opcodes C..F carry a second operand nibble (hi,lo pair).
    function automatic logic is_long(input logic [3:0] opc);
        return opc[3:2] == 2'b11;
    endfunction

    function automatic logic uses_mem(input logic [3:0] opc);
        return (opc <= OP_LDM) || (opc == OP_DEVW) || (opc == OP_STM);
    endfunction

    function automatic alu_op_e mem_alu_op(input logic [3:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_OR:   return ALU_OR;
            OP_AND:  return ALU_AND;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/moonbase_alu.sv
// 4-bit combinational ALU; results wrap modulo 16.
module moonbase_alu
    import moonbase_cpu_pkg::*;
(
    input  alu_op_e    op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);

    always_comb begin
        y = b;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_XOR:  y = a ^ b;
            ALU_PASS: y = b;
            ALU_ADDI: y = a + b;
            default:  y = b;
        endcase
    end

endmodule

// File: rtl/moonbase_cpu_4bit.sv
// Nibble-serial 4-bit CPU with a multiplexed 8-bit bus (address phase / data phase).
// Optional macro MOONBASE_INPUT_PORT_EN enables opcode 9 (load io_in[7:6] into A).
module moonbase_cpu_4bit
    import moonbase_cpu_pkg::*;
#(
    parameter int MAX_COUNT = 1000
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int CW = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT);
    localparam logic [CW-1:0] LAST = CW'((MAX_COUNT > 0) ? MAX_COUNT - 1 : 0);

    logic       clk, rst_n;
    logic [3:0] rdata;
    logic [1:0] in_port;

    assign clk     = io_in[0];
    assign rst_n   = io_in[1];
    assign rdata   = io_in[5:2];
    assign in_port = io_in[7:6];

`ifndef MOONBASE_INPUT_PORT_EN
    logic unused_in_port;
    assign unused_in_port = ^in_port;
`endif

    state_e        state_q, state_d;
    logic [6:0]    pc_q, pc_d;
    logic [6:0]    x_q, x_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    op_q, op_d;
    logic [3:0]    d1_q, d1_d;
    logic [CW-1:0] count_q, count_d;

    alu_op_e    alu_op;
    logic [3:0] alu_b, alu_y;
    logic [6:0] mem_addr, jmp_tgt;

    moonbase_alu u_alu (
        .op (alu_op),
        .a  (a_q),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign mem_addr = x_q + {3'b000, d1_q};
    assign jmp_tgt  = {d1_q[2:0], rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        x_d     = x_q;
        a_d     = a_q;
        op_d    = op_q;
        d1_d    = d1_q;
        count_d = count_q;
        alu_op  = ALU_PASS;
        alu_b   = rdata;
        io_out  = IDLE_OUT;

        case (state_q)
            ST_WAIT: begin
                if (count_q == LAST) begin
                    state_d = ST_FETCH_A;
                    pc_d    = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_FETCH_A: begin
                io_out  = {1'b1, pc_q};
                state_d = ST_FETCH_D;
            end
            ST_FETCH_D: begin
                op_d    = rdata;
                state_d = ST_OP1_A;
            end
            ST_OP1_A: begin
                io_out  = {1'b1, pc_q + 7'd1};
                state_d = ST_OP1_D;
            end
            ST_OP1_D: begin
                d1_d = rdata;
                if (is_long(op_q)) begin
                    state_d = ST_OP2_A;
                end else if (uses_mem(op_q)) begin
                    state_d = ST_MEM_A;
                end else begin
                    // Immediate-only instructions retire here; 7 (and 9 when disabled) do nothing.
                    state_d = ST_FETCH_A;
                    pc_d    = pc_q + 7'd2;
                    case (op_q)
                        OP_ADDI: begin
                            alu_op = ALU_ADDI;
                            a_d    = alu_y;
                        end
                        OP_LDI: begin
                            alu_op = ALU_PASS;
                            a_d    = alu_y;
                        end
`ifdef MOONBASE_INPUT_PORT_EN
                        OP_IN: begin
                            alu_op = ALU_PASS;
                            alu_b  = {2'b00, in_port};
                            a_d    = alu_y;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_OP2_A: begin
                io_out  = {1'b1, pc_q + 7'd2};
                state_d = ST_OP2_D;
            end
            ST_OP2_D: begin
                state_d = ST_FETCH_A;
                pc_d    = pc_q + 7'd3;
                case (op_q)
                    OP_LDX: x_d = jmp_tgt;
                    OP_JNZ: if (a_q != 4'h0) pc_d = jmp_tgt;
                    OP_JZ:  if (a_q == 4'h0) pc_d = jmp_tgt;
                    OP_JMP: pc_d = jmp_tgt;
                    default: ;
                endcase
            end
            ST_MEM_A: begin
                io_out  = {1'b1, mem_addr};
                state_d = ST_MEM_D;
            end
            ST_MEM_D: begin
                state_d = ST_FETCH_A;
                pc_d    = pc_q + 7'd2;
                if (op_q == OP_DEVW) begin
                    io_out = {2'b00, 1'b1, 1'b0, a_q};
                end else if (op_q == OP_STM) begin
                    io_out = {2'b00, 1'b0, 1'b1, a_q};
                end else begin
                    alu_op = mem_alu_op(op_q);
                    a_d    = alu_y;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            pc_q    <= '0;
            x_q     <= '0;
            a_q     <= '0;
            op_q    <= '0;
            d1_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            x_q     <= x_d;
            a_q     <= a_d;
            op_q    <= op_d;
            d1_q    <= d1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_moonbase_cpu_4bit.sv
// Directed bench for moonbase_cpu_4bit with a 128-nibble SRAM model and device-write log.
module tb_moonbase_cpu_4bit;

    localparam int MC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rdata = 4'h0;
    logic [1:0] inp = 2'b00;
    logic [7:0] io_in, io_out;

    assign io_in = {inp, rdata, rst_n, clk};

    moonbase_cpu_4bit #(.MAX_COUNT(MC)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [3:0]  mem [128];
    logic [6:0]  bus_addr = 7'h00;
    logic [10:0] dev_log [$];
    logic [10:0] sram_log [$];
    logic [6:0]  aph_log [$];

    // Bus model: latch address in the address phase, commit strobes in the data phase.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io_out[7]) begin
                bus_addr = io_out[6:0];
                aph_log.push_back(io_out[6:0]);
            end else begin
                if (!io_out[5]) begin
                    mem[bus_addr] = io_out[3:0];
                    sram_log.push_back({bus_addr, io_out[3:0]});
                end
                if (!io_out[4]) dev_log.push_back({bus_addr, io_out[3:0]});
            end
            rdata = mem[bus_addr];
        end
    end

    task automatic start_prog();
        rst_n = 1'b0;
        inp   = 2'b00;
        for (int i = 0; i < 128; i++) mem[i] = 4'h0;
        dev_log.delete();
        sram_log.delete();
        aph_log.delete();
        bus_addr = 7'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [6:0] base, input logic [63:0] code, input int n);
        for (int i = 0; i < n; i++) mem[base + 7'(i)] = code[63 - 4*i -: 4];
    endtask

    task automatic wait_for(input int ndev, input int nsram, input int naph, input int budget,
                            output bit ok);
        int c = 0;
        while ((dev_log.size() < ndev || sram_log.size() < nsram || aph_log.size() < naph)
               && c < budget) begin
            @(posedge clk);
            c++;
        end
        ok = (dev_log.size() >= ndev) && (sram_log.size() >= nsram) && (aph_log.size() >= naph);
    endtask

    task automatic test_reset();
        int bad;
        start_prog();
        load(7'h00, 64'hF000_0000_0000_0000, 3);
        #1;
        vecs++;
        if (io_out !== 8'h30) begin
            errs++;
            $display("FAIL reset_out: got %h want 30", io_out);
        end
        release_rst();
        bad = 0;
        for (int i = 0; i < MC - 1; i++) begin
            @(posedge clk); #1;
            if (io_out !== 8'h30) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL wait_idle: %0d non-idle cycles, want 0", bad);
        end
        @(posedge clk); #1;
        vecs++;
        if (io_out !== 8'h80) begin
            errs++;
            $display("FAIL first_fetch: got %h want 80", io_out);
        end
        @(posedge clk); #1;
        vecs++;
        if (io_out !== 8'h30) begin
            errs++;
            $display("FAIL read_data_phase: got %h want 30", io_out);
        end
    endtask

    task automatic test_count_loop();
        bit ok;
        logic [10:0] got, exp;
        start_prog();
        load(7'h00, 64'h80C5_0AEB_0810_0D05, 16);
        mem[7'h10] = 4'hA;
        mem[7'h11] = 4'hE;
        release_rst();
        wait_for(17, 0, 0, 3000, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL count_timeout: got %0d device writes want 17", dev_log.size());
        end
        for (int i = 0; i < 17; i++) begin
            exp = {7'h5e, (i < 16) ? 4'(i) : 4'h0};
            got = (i < dev_log.size()) ? dev_log[i] : 'x;
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL count_dev[%0d]: got %h want %h", i, got, exp);
            end
        end
        got = (sram_log.size() >= 16) ? sram_log[15] : 'x;
        vecs++;
        if (got !== {7'h50, 4'hF}) begin
            errs++;
            $display("FAIL count_sram_last: got %h want %h", got, {7'h50, 4'hF});
        end
    endtask

    task automatic test_alu();
        bit ok;
        logic [3:0]  exp_v [5] = '{4'h2, 4'hE, 4'h8, 4'h6, 4'hA};
        logic [10:0] got;
        start_prog();
        load(7'h00, 64'hC508_C10A_E8C2_0AE8, 16);
        load(7'h10, 64'hC30A_E8C4_0AE5_0AEF, 16);
        load(7'h20, 64'h1F00_0000_0000_0000, 2);
        mem[7'h50] = 4'hA;
        release_rst();
        wait_for(5, 0, 0, 1000, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL alu_timeout: got %0d device writes want 5", dev_log.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < dev_log.size()) ? dev_log[i] : 'x;
            vecs++;
            if (got !== {7'h5e, exp_v[i]}) begin
                errs++;
                $display("FAIL alu_dev[%0d]: got %h want %h", i, got, {7'h5e, exp_v[i]});
            end
        end
        vecs++;
        if (sram_log.size() != 0) begin
            errs++;
            $display("FAIL alu_no_sram: got %0d writes want 0", sram_log.size());
        end
    endtask

    task automatic test_jump_loop();
        bit ok;
        logic [6:0] got, exp;
        start_prog();
        load(7'h00, 64'hF300_0000_0000_0000, 3);
        load(7'h30, 64'hF300_0000_0000_0000, 3);
        release_rst();
        wait_for(0, 0, 21, 300, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL jmp_timeout: got %0d address phases want 21", aph_log.size());
        end
        for (int i = 0; i < 21; i++) begin
            exp = (i < 3) ? 7'(i) : 7'h30 + 7'((i - 3) % 3);
            got = (i < aph_log.size()) ? aph_log[i] : 'x;
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL jmp_addr[%0d]: got %h want %h", i, got, exp);
            end
        end
        vecs++;
        if (dev_log.size() + sram_log.size() != 0) begin
            errs++;
            $display("FAIL jmp_no_writes: got %0d writes want 0", dev_log.size() + sram_log.size());
        end
    endtask

    task automatic test_reset_midwrite();
        int c, bad;
        start_prog();
        load(7'h00, 64'h87C6_0B3F_0700_0000, 10);
        release_rst();
        c = 0;
        while (io_out !== 8'hE3 && c < 300) begin
            @(negedge clk);
            c++;
        end
        vecs++;
        if (io_out !== 8'hE3) begin
            errs++;
            $display("FAIL midw_mem_a: got %h want e3", io_out);
        end
        @(posedge clk); #1;
        vecs++;
        if (io_out !== 8'h17) begin
            errs++;
            $display("FAIL midw_strobe: got %h want 17", io_out);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (io_out !== 8'h30) begin
            errs++;
            $display("FAIL midw_reset_out: got %h want 30", io_out);
        end
        repeat (3) @(negedge clk);
        vecs++;
        if (sram_log.size() != 0 || mem[7'h63] !== 4'h0) begin
            errs++;
            $display("FAIL midw_no_write: got %0d writes mem=%h want 0 writes mem=0",
                     sram_log.size(), mem[7'h63]);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < MC - 1; i++) begin
            @(posedge clk); #1;
            if (io_out !== 8'h30) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL midw_wait_idle: %0d non-idle cycles, want 0", bad);
        end
        @(posedge clk); #1;
        vecs++;
        if (io_out !== 8'h80) begin
            errs++;
            $display("FAIL midw_first_fetch: got %h want 80", io_out);
        end
    endtask

    task automatic test_input_port();
        bit ok;
        logic [10:0] got, exp;
        start_prog();
        inp = 2'b10;
        load(7'h00, 64'h8590_A0F0_6000_0000, 9);
        release_rst();
        wait_for(1, 0, 0, 300, ok);
`ifdef MOONBASE_INPUT_PORT_EN
        exp = {7'h00, 4'h2};
`else
        exp = {7'h00, 4'h5};
`endif
        got = (dev_log.size() > 0) ? dev_log[0] : 'x;
        vecs++;
        if (!ok || got !== exp) begin
            errs++;
            $display("FAIL input_port: got %h want %h", got, exp);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [6:0]  exp_a [10] = '{7'h00, 7'h01, 7'h02, 7'h7F, 7'h00,
                                   7'h01, 7'h02, 7'h03, 7'h04, 7'h00};
        logic [6:0]  ga;
        logic [10:0] got;
        start_prog();
        load(7'h00, 64'h89C7_FB2F_0700_0000, 10);
        release_rst();
        wait_for(0, 1, 0, 300, ok);
        got = (sram_log.size() > 0) ? sram_log[0] : 'x;
        vecs++;
        if (!ok || got !== {7'h01, 4'h9}) begin
            errs++;
            $display("FAIL wrap_x_sram: got %h want %h", got, {7'h01, 4'h9});
        end
        start_prog();
        load(7'h00, 64'hF7FA_0F05_0000_0000, 8);
        mem[7'h7F] = 4'h8;
        release_rst();
        wait_for(1, 0, 10, 300, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL wrap_pc_timeout: got %0d phases %0d writes want 10 and 1",
                     aph_log.size(), dev_log.size());
        end
        for (int i = 0; i < 10; i++) begin
            ga = (i < aph_log.size()) ? aph_log[i] : 'x;
            vecs++;
            if (ga !== exp_a[i]) begin
                errs++;
                $display("FAIL wrap_pc_addr[%0d]: got %h want %h", i, ga, exp_a[i]);
            end
        end
        got = (dev_log.size() > 0) ? dev_log[0] : 'x;
        vecs++;
        if (got !== {7'h00, 4'hF}) begin
            errs++;
            $display("FAIL wrap_pc_dev: got %h want %h", got, {7'h00, 4'hF});
        end
    endtask

    initial begin
        test_reset();
        test_count_loop();
        test_alu();
        test_jump_loop();
        test_reset_midwrite();
        test_input_port();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
